// File: rtl/fx2_pattern_gen_if.sv
// FX2 slave-FIFO read-side signal bundle between the pattern generator (master)
// and the FX2 FIFO2 endpoint (slave).
interface fx2_pattern_gen_if;
    logic [7:0] FIFO_DATAIN;
    logic       FIFO2_data_available;
    logic       FIFO_RD;
    logic       FIFO_DATAIN_OE;
    logic [1:0] FIFO_FIFOADR;

    modport master (
        input  FIFO_DATAIN,
        input  FIFO2_data_available,
        output FIFO_RD,
        output FIFO_DATAIN_OE,
        output FIFO_FIFOADR
    );

    modport slave (
        output FIFO_DATAIN,
        output FIFO2_data_available,
        input  FIFO_RD,
        input  FIFO_DATAIN_OE,
        input  FIFO_FIFOADR
    );
endinterface

// File: rtl/fx2_pattern_gen.sv
// Drains FX2 FIFO2 into a small circular buffer and replays the bytes on PATTERN
// at one byte per (divisor+1) clocks while enabled.
module fx2_pattern_gen #(
    parameter int DEPTH_LOG2 = 3,
    parameter int DIV_WIDTH  = 16
) (
    input  logic                  FIFO_clk,
    input  logic                  reset_n,
    fx2_pattern_gen_if.master     fx2,
    input  logic                  enable,
    input  logic [DIV_WIDTH-1:0]  divisor,
    output logic [7:0]            PATTERN,
    output logic                  pattern_valid,
    output logic                  underrun,
    output logic [DEPTH_LOG2:0]   level
);

    localparam int                  DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FULL  = (DEPTH_LOG2 + 1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, SELECT, READ, GAP} state_t;

    state_t                 state_reg, state_next;
    logic                   rd_reg, rd_next;
    logic                   oe_reg, oe_next;
    logic                   push, pop, tick;
    logic [DEPTH_LOG2-1:0]  wr_ptr_reg, rd_ptr_reg;
    logic [DEPTH_LOG2:0]    level_reg;
    logic [DIV_WIDTH-1:0]   count_reg;
    logic [7:0]             pattern_reg;
    logic                   valid_reg;
    logic                   underrun_reg;
    logic [7:0]             mem [DEPTH];

    // The full check uses the occupancy seen in READ, so a same-edge pop never makes room early.
    assign push = (state_reg == READ) && fx2.FIFO2_data_available && (level_reg != FULL);
    assign tick = enable && (count_reg == '0);
    assign pop  = tick && (level_reg != '0);

    always_ff @(posedge FIFO_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= IDLE;
            rd_reg    <= 1'b0;
            oe_reg    <= 1'b0;
        end else begin
            state_reg <= state_next;
            rd_reg    <= rd_next;
            oe_reg    <= oe_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    state_next = SELECT;
            SELECT:  state_next = READ;
            READ:    state_next = push ? GAP : READ;
            GAP:     state_next = READ;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        oe_next = (state_reg != IDLE);
        rd_next = push;
    end

    // Storage has no reset: pointers and level define what is valid.
    always_ff @(posedge FIFO_clk) begin
        if (push) begin
            mem[wr_ptr_reg] <= fx2.FIFO_DATAIN;
        end
    end

    always_ff @(posedge FIFO_clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            level_reg  <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            case ({push, pop})
                2'b10:   level_reg <= level_reg + 1'b1;
                2'b01:   level_reg <= level_reg - 1'b1;
                default: level_reg <= level_reg;
            endcase
        end
    end

    always_ff @(posedge FIFO_clk or negedge reset_n) begin
        if (!reset_n) begin
            count_reg    <= '0;
            pattern_reg  <= 8'h00;
            valid_reg    <= 1'b0;
            underrun_reg <= 1'b0;
        end else begin
            if (!enable) begin
                count_reg <= '0;
            end else if (tick) begin
                count_reg <= divisor;
            end else begin
                count_reg <= count_reg - 1'b1;
            end

            if (pop) begin
                pattern_reg <= mem[rd_ptr_reg];
            end
            valid_reg <= pop;

            if (!enable) begin
                underrun_reg <= 1'b0;
            end else if (tick && (level_reg == '0)) begin
                underrun_reg <= 1'b1;
            end
        end
    end

    assign fx2.FIFO_RD        = rd_reg;
    assign fx2.FIFO_DATAIN_OE = oe_reg;
    assign fx2.FIFO_FIFOADR   = 2'b00;
    assign PATTERN            = pattern_reg;
    assign pattern_valid      = valid_reg;
    assign underrun           = underrun_reg;
    assign level              = level_reg;

endmodule

// File: tb/tb_fx2_pattern_gen.sv
// Randomized and directed bench: FX2 FIFO2 and the pattern buffer are modelled as
// queues and the playback schedule as absolute tick times.
module tb_fx2_pattern_gen;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic [15:0] divisor;
    logic [7:0]  pattern;
    logic        pattern_valid;
    logic        underrun;
    logic [3:0]  level;

    fx2_pattern_gen_if fx();

    always #5 clk = ~clk;

    fx2_pattern_gen #(.DEPTH_LOG2(3), .DIV_WIDTH(16)) dut (
        .FIFO_clk      (clk),
        .reset_n       (rst_n),
        .fx2           (fx),
        .enable        (enable),
        .divisor       (divisor),
        .PATTERN       (pattern),
        .pattern_valid (pattern_valid),
        .underrun      (underrun),
        .level         (level)
    );

    int         n_checks = 0;
    int         n_errors = 0;
    logic [7:0] host_q[$];
    logic [7:0] buf_q[$];
    logic [7:0] got_log[$];
    int         pv_time[$];
    logic [7:0] m_pat;
    bit         m_under;
    bit         armed;
    int         next_tick;
    int         cyc;
    int         since;
    bit         prev_rd;
    int         n_rd;

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic present();
        fx.FIFO2_data_available = (host_q.size() != 0);
        fx.FIFO_DATAIN          = (host_q.size() != 0) ? host_q[0] : 8'h00;
    endtask

    task automatic host_add(input logic [7:0] b);
        host_q.push_back(b);
        present();
    endtask

    task automatic reset_model();
        buf_q.delete();
        m_pat   = 8'h00;
        m_under = 1'b0;
        armed   = 1'b1;
        since   = 0;
        prev_rd = 1'b0;
    endtask

    // One clock: sample #1 after the edge and compare against the model.
    task automatic cycle();
        bit         en_e, rst_e, host_b, tick, pop;
        int         lvl_b;
        logic [15:0] div_e;
        logic [7:0] b;
        en_e   = enable;
        rst_e  = rst_n;
        div_e  = divisor;
        lvl_b  = buf_q.size();
        host_b = (host_q.size() != 0);
        @(posedge clk);
        #1;
        cyc++;
        if (!rst_e) begin
            reset_model();
            check_value("rst_rd", fx.FIFO_RD, 0);
            check_value("rst_oe", fx.FIFO_DATAIN_OE, 0);
            check_value("rst_pattern", pattern, 0);
            check_value("rst_pvalid", pattern_valid, 0);
            check_value("rst_underrun", underrun, 0);
            check_value("rst_level", level, 0);
        end else begin
            since++;
            tick = 1'b0;
            if (!en_e) begin
                armed = 1'b1;
            end else if (armed || cyc == next_tick) begin
                tick      = 1'b1;
                armed     = 1'b0;
                next_tick = cyc + int'(div_e) + 1;
            end
            pop = tick && (lvl_b > 0);
            if (!en_e) m_under = 1'b0;
            else if (tick && lvl_b == 0) m_under = 1'b1;
            if (pop) m_pat = buf_q.pop_front();

            check_value("pattern_valid", pattern_valid, pop);
            check_value("pattern", pattern, m_pat);
            check_value("underrun", underrun, m_under);
            if (pattern_valid) begin
                got_log.push_back(pattern);
                pv_time.push_back(cyc);
            end

            if (fx.FIFO_RD) begin
                check_value("rd_avail", host_b, 1);
                check_value("rd_room", lvl_b < 8, 1);
                check_value("rd_spacing", prev_rd, 0);
                if (host_b) begin
                    b = host_q.pop_front();
                    buf_q.push_back(b);
                end
                n_rd++;
            end else if (host_b && lvl_b < 8 && since >= 3 && !prev_rd) begin
                check_value("rd_stall", fx.FIFO_RD, 1);
            end
            prev_rd = fx.FIFO_RD;

            check_value("oe", fx.FIFO_DATAIN_OE, since >= 2);
            check_value("fifoadr", fx.FIFO_FIFOADR, 0);
            check_value("level", level, buf_q.size());
            present();
        end
    endtask

    initial begin
        logic [7:0] stash [12];
        logic [7:0] t3_exp [3];
        int         n0;
        bit         found;

        rst_n = 1'b0; enable = 1'b0; divisor = 16'd0;
        cyc = 0; n_rd = 0; next_tick = 0;
        reset_model();
        present();
        repeat (3) cycle();

        // Release with FIFO2 empty: OE after two edges, no reads.
        rst_n = 1'b1;
        cycle();
        check_value("t1_oe_edge1", fx.FIFO_DATAIN_OE, 0);
        cycle();
        check_value("t1_oe_edge2", fx.FIFO_DATAIN_OE, 1);
        repeat (6) cycle();
        check_value("t1_no_rd", n_rd, 0);
        check_value("t1_level", level, 0);

        // Prefill three bytes with playback off.
        n0 = n_rd;
        host_add(8'hA5); host_add(8'h5A); host_add(8'h3C);
        repeat (12) cycle();
        check_value("t2_rd_count", n_rd - n0, 3);
        check_value("t2_level", level, 3);
        check_value("t2_pattern", pattern, 8'h00);

        // Playback at divisor 3, fourth tick underruns.
        got_log.delete(); pv_time.delete();
        t3_exp[0] = 8'hA5; t3_exp[1] = 8'h5A; t3_exp[2] = 8'h3C;
        divisor = 16'd3; enable = 1'b1;
        repeat (14) cycle();
        check_value("t3_pulses", got_log.size(), 3);
        for (int i = 0; i < 3 && i < got_log.size(); i++) begin
            check_value("t3_byte", got_log[i], t3_exp[i]);
            if (i > 0) check_value("t3_spacing", pv_time[i] - pv_time[i-1], 4);
        end
        check_value("t3_underrun", underrun, 1);
        check_value("t3_hold", pattern, 8'h3C);

        // Twelve host bytes: exactly eight fetched, then drain at divisor 0.
        enable = 1'b0;
        cycle();
        check_value("t4_underrun_clr", underrun, 0);
        n0 = n_rd;
        for (int i = 0; i < 12; i++) begin
            stash[i] = 8'($urandom);
            host_add(stash[i]);
        end
        repeat (40) cycle();
        check_value("t4_rd_count", n_rd - n0, 8);
        check_value("t4_level_full", level, 8);
        got_log.delete();
        divisor = 16'd0; enable = 1'b1;
        repeat (60) cycle();
        check_value("t4_pop_count", got_log.size(), 12);
        for (int i = 0; i < 12 && i < got_log.size(); i++) begin
            check_value("t4_order", got_log[i], stash[i]);
        end
        check_value("t4_underrun", underrun, 1);

        // One clock of enable low clears underrun; re-enable pops at once.
        enable = 1'b0;
        cycle();
        check_value("t5_underrun_clr", underrun, 0);
        stash[0] = 8'($urandom); stash[1] = 8'($urandom);
        host_add(stash[0]); host_add(stash[1]);
        repeat (6) cycle();
        divisor = 16'd5; enable = 1'b1;
        cycle();
        check_value("t5_immediate_pop", pattern_valid, 1);
        check_value("t5_first_byte", pattern, stash[0]);
        repeat (12) cycle();

        // Random traffic, enable toggling and divisor changes.
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0 && host_q.size() < 24) host_add(8'($urandom));
            if ($urandom_range(0, 29) == 0) enable = ~enable;
            if ($urandom_range(0, 19) == 0) divisor = 16'($urandom_range(0, 6));
            cycle();
        end

        // Asynchronous reset while RD is high at level 5.
        enable = 1'b1; divisor = 16'd0;
        host_q.delete(); present();
        repeat (30) cycle();
        enable = 1'b0;
        cycle();
        for (int i = 0; i < 12; i++) host_add(8'($urandom));
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            cycle();
            if (fx.FIFO_RD && level == 4'd5) found = 1'b1;
        end
        check_value("t6_rd_at_level5", found, 1);
        rst_n = 1'b0;
        #1;
        check_value("t6_async_rd", fx.FIFO_RD, 0);
        check_value("t6_async_oe", fx.FIFO_DATAIN_OE, 0);
        check_value("t6_async_level", level, 0);
        check_value("t6_async_pattern", pattern, 0);
        check_value("t6_async_underrun", underrun, 0);
        reset_model();
        host_q.delete(); present();
        enable = 1'b1; divisor = 16'd2;
        repeat (2) cycle();
        rst_n = 1'b1;
        got_log.delete();
        repeat (10) cycle();
        check_value("t6_no_stale_pop", got_log.size(), 0);
        check_value("t6_underrun", underrun, 1);
        check_value("t6_level", level, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
